clock_set: RTL

- Time-entry front end for the digital clock: turns two active-low pushbuttons into hours/minutes/seconds preset values and an active-low load strobe.
- Its outputs feed the clock counter's nLoadNow_i and preset inputs. It is the input side of the clock, where the bin2bcd/hex7seg chain is the display side.
- Holds a field-select state machine, per-button synchronise/debounce, and wrap-around field increment.

---
 rtl/clock_pkg.sv | 23 ++
 rtl/key_debounce.sv | 55 +++++
 rtl/clock_set.sv | 89 ++++++++
 3 files changed

// File: rtl/clock_pkg.sv
// Shared definitions for the clock time-entry front end.
package clock_pkg;

  localparam int unsigned FieldW = 7;

  // State codes double as the field_o selector values.
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SET_HRS  = 2'd1,
    SET_MINS = 2'd2,
    SET_SECS = 2'd3
  } state_e;

  localparam logic [FieldW-1:0] HRS_MAX     = 7'd23;
  localparam logic [FieldW-1:0] MIN_SEC_MAX = 7'd59;

  // Increment with wrap to zero; the limit is tested before adding.
  function automatic logic [FieldW-1:0] wrap_inc(input logic [FieldW-1:0] val,
                                                 input logic [FieldW-1:0] max);
    return (val >= max) ? '0 : val + FieldW'(1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Synchroniser, debounce counter and press (1->0) detector for one active-low button.
module key_debounce #(
  parameter int unsigned db_tc_p = 499999
) (
  input  logic clk_i,
  input  logic nRst_i,
  input  logic nKey_i,
  output logic press_o
);

  localparam int unsigned CntW = (db_tc_p < 2) ? 1 : $clog2(db_tc_p + 1);
  localparam logic [CntW-1:0] TcCnt = CntW'(db_tc_p);

  logic            sync1_q, sync2_q;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= nKey_i;
      sync2_q <= sync1_q;
    end
  end

  // Count while the synchronised level disagrees with the accepted one; accept at terminal count.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    press_o = 1'b0;
    if (sync2_q != level_q) begin
      if (cnt_q == TcCnt) begin
        level_d = sync2_q;
        press_o = ~sync2_q;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
  end

  // Counter and accepted-level registers.
  always_ff @(posedge clk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/clock_set.sv
// Time-entry front end: mode/increment buttons to hh:mm:ss presets and a load strobe.
module clock_set
  import clock_pkg::*;
#(
  parameter int unsigned db_tc_p = 499999
) (
  input  logic              clk_i,
  input  logic              nRst_i,
  input  logic              nMode_i,
  input  logic              nInc_i,
  output logic [FieldW-1:0] hrs_o,
  output logic [FieldW-1:0] mins_o,
  output logic [FieldW-1:0] secs_o,
  output logic [1:0]        field_o,
  output logic              nLoadNow_o
);

  logic mode_press, inc_press;

  state_e            state_q, state_d;
  logic [FieldW-1:0] hrs_q, hrs_d, mins_q, mins_d, secs_q, secs_d;
  logic              nload_q, nload_d;

  key_debounce #(.db_tc_p(db_tc_p)) u_mode_db (
    .clk_i   (clk_i),
    .nRst_i  (nRst_i),
    .nKey_i  (nMode_i),
    .press_o (mode_press)
  );

  key_debounce #(.db_tc_p(db_tc_p)) u_inc_db (
    .clk_i   (clk_i),
    .nRst_i  (nRst_i),
    .nKey_i  (nInc_i),
    .press_o (inc_press)
  );

  // Field-select FSM, field increments and load strobe; mode beats a simultaneous increment.
  always_comb begin
    state_d = state_q;
    hrs_d   = hrs_q;
    mins_d  = mins_q;
    secs_d  = secs_q;
    nload_d = 1'b1;
    if (mode_press) begin
      case (state_q)
        IDLE:     state_d = SET_HRS;
        SET_HRS:  state_d = SET_MINS;
        SET_MINS: state_d = SET_SECS;
        SET_SECS: begin
          state_d = IDLE;
          nload_d = 1'b0;
        end
        default:  state_d = IDLE;
      endcase
    end else if (inc_press) begin
      case (state_q)
        SET_HRS:  hrs_d  = wrap_inc(hrs_q, HRS_MAX);
        SET_MINS: mins_d = wrap_inc(mins_q, MIN_SEC_MAX);
        SET_SECS: secs_d = wrap_inc(secs_q, MIN_SEC_MAX);
        default:  ;
      endcase
    end
  end

  // State, field and strobe registers.
  always_ff @(posedge clk_i or negedge nRst_i) begin
    if (!nRst_i) begin
      state_q <= IDLE;
      hrs_q   <= '0;
      mins_q  <= '0;
      secs_q  <= '0;
      nload_q <= 1'b1;
    end else begin
      state_q <= state_d;
      hrs_q   <= hrs_d;
      mins_q  <= mins_d;
      secs_q  <= secs_d;
      nload_q <= nload_d;
    end
  end

  assign hrs_o      = hrs_q;
  assign mins_o     = mins_q;
  assign secs_o     = secs_q;
  assign field_o    = state_q;
  assign nLoadNow_o = nload_q;

endmodule
